aes_out_arbiter: RTL and testbench
==================================

Name: aes_out_arbiter

Overview:
- Shares one 128-bit AES output holding register between the encryption and decryption cores.
- Sequences each result to the downstream XTS tweak-XOR stage over a valid/ready handshake.
- Grants the two cores round-robin and keeps per-source completion counts for status readback.
- Sits between the AES enc/dec cores and the XTS post-whitening stage. It replaces direct write strobes into the output register.

Parameters:
- DATA_W, 128, block width in bits.
- CNT_W, 16, width of each completion counter.

Ports:
- inClk  input  1  clock; all logic on rising edge.
- inRst  input  1  synchronous, active-high reset.
- inEncReq  input  1  encryption core has a result; held until outEncAck.
- inEncData  input  DATA_W  encryption result; stable while inEncReq=1.
- outEncAck  output  1  one-cycle pulse: encryption result captured.
- inDecReq  input  1  decryption core has a result; held until outDecAck.
- inDecData  input  DATA_W  decryption result; stable while inDecReq=1.
- outDecAck  output  1  one-cycle pulse: decryption result captured.
- outValid  output  1  outData holds a block for downstream.
- inReady  input  1  downstream accepts the block.
- outData  output  DATA_W  held block.
- outSrc  output  1  source of held block: 0 = enc, 1 = dec.
- outBusy  output  1  FSM not in IDLE.
- outEncCnt  output  CNT_W  completed encryption transfers.
- outDecCnt  output  CNT_W  completed decryption transfers.

Behaviour:
- Reset (inRst=1 at an edge) overrides everything, including mid-transfer. Resulting state:
  - FSM=IDLE; outValid=0; outData=0; outSrc=0.
  - outEncAck=0; outDecAck=0; outBusy=0.
  - Both counters=0.
  - Round-robin pointer lastSrc=1, so enc wins the first contention.
  - Any held block is discarded without an ack. Requesters must re-present after reset.
- FSM states: IDLE, HOLD.
- IDLE, at the clock edge:
  - No request: stay in IDLE.
  - Only inEncReq: capture inEncData, outSrc<=0, outEncAck<=1, go to HOLD.
  - Only inDecReq: capture inDecData, outSrc<=1, outDecAck<=1, go to HOLD.
  - Both requests: grant the source != lastSrc and set lastSrc to the granted source. The losing request stays pending; it is not acked and its data is not touched.
  - lastSrc updates on every grant, contended or not.
- HOLD:
  - outValid=1. outData and outSrc are stable until the transfer completes.
  - The ack is high only in the first HOLD cycle, i.e. the cycle after capture. It is registered and never combinational from the request.
  - Requests are ignored in HOLD. A requester sees the ack at the next edge and drops or updates its request there.
  - Edge with inReady=1: transfer completes. Increment the counter for outSrc (modulo 2^CNT_W, wraps silently), outValid<=0, go to IDLE. outData keeps its last value.
  - Edge with inReady=0: stay in HOLD, no counter change.
- Latency:
  - Request to outValid: 1 cycle.
  - Minimum occupancy: 2 cycles per block (capture edge, then complete edge with inReady=1). The IDLE cycle between blocks is mandatory.
  - Peak throughput: 1 block per 2 cycles.
- inReady while outValid=0 is ignored.
- outBusy = (FSM==HOLD).
- outEncAck and outDecAck are never high in the same cycle.
- A request dropped before its ack is legal. It is simply not granted.
- A request held continuously while the other source keeps requesting is granted within 2 transfers (fairness bound).

Test Plan:
1. Reset, then single enc: inEncReq=1, inEncData=0x00112233445566778899AABBCCDDEEFF, inReady=1.
   -> outEncAck and outValid high in the cycle after the request; outData matches; outSrc=0.
   -> Next edge: outValid=0; outEncCnt=1; outDecCnt=0.
2. Contention from reset: enc and dec both request with inReady=1.
   -> Grant order enc, dec, enc, dec, with each request re-asserted after its ack.
   -> After 4 blocks: outEncCnt=2, outDecCnt=2. Acks never overlap.
3. Backpressure: dec block 0xDEAD…BEEF captured, inReady=0 for 5 cycles.
   -> outValid, outData and outSrc=1 stay stable; outDecAck pulses exactly once.
   -> Enc request during HOLD is not acked. After inReady=1 it is granted on the next IDLE edge.
4. Reset mid-HOLD: assert inRst while outValid=1.
   -> Next cycle: outValid=0, outData=0, counters=0, outBusy=0.
   -> After reset, with both requesting, enc is granted first.
5. Counter wrap: set CNT_W=4 and run 17 enc transfers.
   -> outEncCnt goes 15 -> 0 -> 1; no effect on outDecCnt.
6. Stray inReady: inReady=1 constantly with no requests for 10 cycles.
   -> outValid=0, counters unchanged, outBusy=0.

Source files
------------

// File: rtl/aes_out_arbiter.sv
// Round-robin arbiter that shares one AES output holding register between the
// encryption and decryption cores and hands each block downstream via valid/ready.
module aes_out_arbiter #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              inClk,
  input  logic              inRst,
  input  logic              inEncReq,
  input  logic [DATA_W-1:0] inEncData,
  output logic              outEncAck,
  input  logic              inDecReq,
  input  logic [DATA_W-1:0] inDecData,
  output logic              outDecAck,
  output logic              outValid,
  input  logic              inReady,
  output logic [DATA_W-1:0] outData,
  output logic              outSrc,
  output logic              outBusy,
  output logic [CNT_W-1:0]  outEncCnt,
  output logic [CNT_W-1:0]  outDecCnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic              last_src_q, last_src_d;
  logic              enc_ack_q, enc_ack_d;
  logic              dec_ack_q, dec_ack_d;
  logic [CNT_W-1:0]  enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic              grant_enc, grant_dec;

  // Under contention the source that was not granted last wins.
  always_comb begin
    grant_enc = inEncReq && (!inDecReq || last_src_q);
    grant_dec = inDecReq && (!inEncReq || !last_src_q);
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    src_d      = src_q;
    last_src_d = last_src_q;
    enc_ack_d  = 1'b0;
    dec_ack_d  = 1'b0;
    enc_cnt_d  = enc_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_enc) begin
          data_d     = inEncData;
          src_d      = 1'b0;
          last_src_d = 1'b0;
          enc_ack_d  = 1'b1;
          state_d    = HOLD;
        end else if (grant_dec) begin
          data_d     = inDecData;
          src_d      = 1'b1;
          last_src_d = 1'b1;
          dec_ack_d  = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Requests are ignored here; data stays put after completion.
        if (inReady) begin
          state_d = IDLE;
          if (src_q) dec_cnt_d = dec_cnt_q + CNT_W'(1);
          else       enc_cnt_d = enc_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      src_q      <= 1'b0;
      last_src_q <= 1'b1;
      enc_ack_q  <= 1'b0;
      dec_ack_q  <= 1'b0;
      enc_cnt_q  <= '0;
      dec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      src_q      <= src_d;
      last_src_q <= last_src_d;
      enc_ack_q  <= enc_ack_d;
      dec_ack_q  <= dec_ack_d;
      enc_cnt_q  <= enc_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
    end
  end

  assign outValid  = (state_q == HOLD);
  assign outBusy   = (state_q == HOLD);
  assign outData   = data_q;
  assign outSrc    = src_q;
  assign outEncAck = enc_ack_q;
  assign outDecAck = dec_ack_q;
  assign outEncCnt = enc_cnt_q;
  assign outDecCnt = dec_cnt_q;

endmodule

// File: tb/tb_aes_out_arbiter.sv
// Directed bench for aes_out_arbiter; a second instance with 4-bit counters covers wrap.
module tb_aes_out_arbiter;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          enc_req, dec_req, ready;
  logic [DW-1:0] enc_data, dec_data;
  logic          enc_ack, dec_ack, valid, src, busy;
  logic [DW-1:0] data;
  logic [15:0]   enc_cnt, dec_cnt;

  logic          w_enc_req, w_dec_req, w_ready;
  logic [DW-1:0] w_enc_data, w_dec_data;
  logic          w_enc_ack, w_dec_ack, w_valid, w_src, w_busy;
  logic [DW-1:0] w_data;
  logic [3:0]    w_enc_cnt, w_dec_cnt;

  int total = 0;
  int bad   = 0;
  int exp_enc = 0;
  int exp_dec = 0;

  localparam logic [DW-1:0] D_T1  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [DW-1:0] D_ENC = 128'hA5A5A5A5_01020304_A5A5A5A5_05060708;
  localparam logic [DW-1:0] D_DEC = 128'h5A5A5A5A_F1F2F3F4_5A5A5A5A_F5F6F7F8;
  localparam logic [DW-1:0] D_DB  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  always #5 clk = ~clk;

  aes_out_arbiter #(.DATA_W(DW), .CNT_W(16)) dut (
    .inClk(clk), .inRst(rst),
    .inEncReq(enc_req), .inEncData(enc_data), .outEncAck(enc_ack),
    .inDecReq(dec_req), .inDecData(dec_data), .outDecAck(dec_ack),
    .outValid(valid), .inReady(ready), .outData(data), .outSrc(src),
    .outBusy(busy), .outEncCnt(enc_cnt), .outDecCnt(dec_cnt)
  );

  aes_out_arbiter #(.DATA_W(DW), .CNT_W(4)) dut_w (
    .inClk(clk), .inRst(rst),
    .inEncReq(w_enc_req), .inEncData(w_enc_data), .outEncAck(w_enc_ack),
    .inDecReq(w_dec_req), .inDecData(w_dec_data), .outDecAck(w_dec_ack),
    .outValid(w_valid), .inReady(w_ready), .outData(w_data), .outSrc(w_src),
    .outBusy(w_busy), .outEncCnt(w_enc_cnt), .outDecCnt(w_dec_cnt)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enc_req = 1'b0; dec_req = 1'b0; ready = 1'b0;
    step(); step();
    rst = 1'b0;
    exp_enc = 0; exp_dec = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (valid !== 1'b0 || busy !== 1'b0 || src !== 1'b0 || data !== '0 ||
        enc_ack !== 1'b0 || dec_ack !== 1'b0 || enc_cnt !== 16'd0 || dec_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b busy=%b src=%b data=%h ea=%b da=%b ec=%0d dc=%0d, want all zero",
               valid, busy, src, data, enc_ack, dec_ack, enc_cnt, dec_cnt);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_single_enc();
    enc_req = 1'b1; enc_data = D_T1; ready = 1'b1;
    step();
    total++;
    if (enc_ack !== 1'b1 || dec_ack !== 1'b0 || valid !== 1'b1 || src !== 1'b0 || data !== D_T1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_capture: got ea=%b da=%b valid=%b src=%b busy=%b data=%h, want ea=1 da=0 valid=1 src=0 busy=1 data=%h",
               enc_ack, dec_ack, valid, src, busy, data, D_T1);
    end
    enc_req = 1'b0;
    step();
    exp_enc++;
    total++;
    if (valid !== 1'b0 || enc_ack !== 1'b0 || enc_cnt !== 16'(exp_enc) || dec_cnt !== 16'd0 || data !== D_T1) begin
      bad++;
      $display("FAIL single_complete: got valid=%b ea=%b ec=%0d dc=%0d data=%h, want valid=0 ea=0 ec=%0d dc=0 data kept",
               valid, enc_ack, enc_cnt, dec_cnt, data, exp_enc);
    end
    $display("single_enc: data=%h ec=%0d", data, enc_cnt);
  endtask

  task automatic test_contention();
    do_reset();
    enc_req = 1'b1; dec_req = 1'b1; ready = 1'b1;
    enc_data = D_ENC; dec_data = D_DEC;
    for (int i = 0; i < 4; i++) begin
      logic want_dec;
      want_dec = (i % 2) == 1;
      step();
      total++;
      if (enc_ack !== !want_dec || dec_ack !== want_dec || src !== want_dec || valid !== 1'b1 ||
          data !== (want_dec ? D_DEC : D_ENC)) begin
        bad++;
        $display("FAIL contention_grant%0d: got ea=%b da=%b src=%b valid=%b, want ea=%b da=%b src=%b valid=1",
                 i, enc_ack, dec_ack, src, valid, !want_dec, want_dec, want_dec);
      end
      step();
      if (want_dec) exp_dec++; else exp_enc++;
      total++;
      if (valid !== 1'b0 || enc_ack !== 1'b0 || dec_ack !== 1'b0) begin
        bad++;
        $display("FAIL contention_idle%0d: got valid=%b ea=%b da=%b, want 0 0 0", i, valid, enc_ack, dec_ack);
      end
      $display("contention: block %0d src=%0d", i, want_dec);
    end
    total++;
    if (enc_cnt !== 16'd2 || dec_cnt !== 16'd2) begin
      bad++;
      $display("FAIL contention_counts: got ec=%0d dc=%0d, want 2 2", enc_cnt, dec_cnt);
    end
    enc_req = 1'b0; dec_req = 1'b0;
  endtask

  task automatic test_backpressure();
    int acks;
    dec_req = 1'b1; dec_data = D_DB; enc_req = 1'b0; ready = 1'b0;
    step();
    acks = (dec_ack === 1'b1) ? 1 : 0;
    total++;
    if (valid !== 1'b1 || src !== 1'b1 || data !== D_DB || enc_ack !== 1'b0) begin
      bad++;
      $display("FAIL bp_capture: got valid=%b src=%b ea=%b data=%h, want valid=1 src=1 ea=0 data=%h",
               valid, src, enc_ack, data, D_DB);
    end
    dec_req = 1'b0; enc_req = 1'b1; enc_data = D_ENC;
    for (int i = 0; i < 5; i++) begin
      step();
      if (dec_ack === 1'b1) acks++;
      total++;
      if (valid !== 1'b1 || src !== 1'b1 || data !== D_DB || enc_ack !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d: got valid=%b src=%b ea=%b busy=%b data=%h, want 1 1 0 1 %h",
                 i, valid, src, enc_ack, busy, data, D_DB);
      end
    end
    total++;
    if (acks != 1) begin
      bad++;
      $display("FAIL bp_ack_pulses: got %0d dec ack pulses, want 1", acks);
    end
    ready = 1'b1;
    step();
    exp_dec++;
    total++;
    if (valid !== 1'b0 || dec_cnt !== 16'(exp_dec) || enc_cnt !== 16'(exp_enc)) begin
      bad++;
      $display("FAIL bp_complete: got valid=%b ec=%0d dc=%0d, want 0 %0d %0d", valid, enc_cnt, dec_cnt, exp_enc, exp_dec);
    end
    step();
    total++;
    if (enc_ack !== 1'b1 || src !== 1'b0 || data !== D_ENC || valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_enc_grant: got ea=%b src=%b valid=%b data=%h, want ea=1 src=0 valid=1 data=%h",
               enc_ack, src, valid, data, D_ENC);
    end
    enc_req = 1'b0;
    step();
    exp_enc++;
    $display("backpressure: dec acks=%0d ec=%0d dc=%0d", acks, enc_cnt, dec_cnt);
  endtask

  task automatic test_reset_mid_hold();
    enc_req = 1'b1; enc_data = D_T1; ready = 1'b0;
    step();
    total++;
    if (valid !== 1'b1) begin
      bad++;
      $display("FAIL midhold_pre: got valid=%b, want 1", valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_enc = 0; exp_dec = 0;
    total++;
    if (valid !== 1'b0 || data !== '0 || enc_cnt !== 16'd0 || dec_cnt !== 16'd0 || busy !== 1'b0 ||
        src !== 1'b0 || enc_ack !== 1'b0 || dec_ack !== 1'b0) begin
      bad++;
      $display("FAIL midhold_reset: got valid=%b data=%h ec=%0d dc=%0d busy=%b src=%b ea=%b da=%b, want all zero",
               valid, data, enc_cnt, dec_cnt, busy, src, enc_ack, dec_ack);
    end
    dec_req = 1'b1; dec_data = D_DEC; enc_data = D_ENC; ready = 1'b1;
    step();
    total++;
    if (enc_ack !== 1'b1 || dec_ack !== 1'b0 || src !== 1'b0 || data !== D_ENC) begin
      bad++;
      $display("FAIL midhold_first_grant: got ea=%b da=%b src=%b, want ea=1 da=0 src=0", enc_ack, dec_ack, src);
    end
    enc_req = 1'b0; dec_req = 1'b0;
    step();
    exp_enc++;
    $display("reset_mid_hold: ec=%0d dc=%0d", enc_cnt, dec_cnt);
  endtask

  task automatic test_counter_wrap();
    int exp_w;
    exp_w = 0;
    w_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      w_enc_req = 1'b1; w_enc_data = DW'(i);
      step();
      w_enc_req = 1'b0;
      step();
      exp_w = (exp_w + 1) % 16;
      total++;
      if (w_enc_cnt !== 4'(exp_w) || w_dec_cnt !== 4'd0 || w_valid !== 1'b0) begin
        bad++;
        $display("FAIL wrap_xfer%0d: got ec=%0d dc=%0d valid=%b, want ec=%0d dc=0 valid=0",
                 i, w_enc_cnt, w_dec_cnt, w_valid, exp_w);
      end
      $display("counter_wrap: xfer %0d ec=%0d", i, w_enc_cnt);
    end
    w_ready = 1'b0;
  endtask

  task automatic test_stray_ready();
    enc_req = 1'b0; dec_req = 1'b0; ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (valid !== 1'b0 || busy !== 1'b0 || enc_cnt !== 16'(exp_enc) || dec_cnt !== 16'(exp_dec)) begin
        bad++;
        $display("FAIL stray_ready%0d: got valid=%b busy=%b ec=%0d dc=%0d, want 0 0 %0d %0d",
                 i, valid, busy, enc_cnt, dec_cnt, exp_enc, exp_dec);
      end
    end
    $display("stray_ready: ec=%0d dc=%0d", enc_cnt, dec_cnt);
  endtask

  initial begin
    rst = 1'b1; enc_req = 1'b0; dec_req = 1'b0; ready = 1'b0;
    enc_data = '0; dec_data = '0;
    w_enc_req = 1'b0; w_dec_req = 1'b0; w_ready = 1'b0;
    w_enc_data = '0; w_dec_data = '0;
    test_reset();
    test_single_enc();
    test_contention();
    test_backpressure();
    test_reset_mid_hold();
    test_counter_wrap();
    test_stray_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Acks must never overlap on either instance.
  always @(negedge clk) begin
    if (!rst && ((enc_ack && dec_ack) || (w_enc_ack && w_dec_ack))) begin
      bad++;
      total++;
      $display("FAIL ack_overlap: got both acks high, want at most one");
    end
  end

endmodule
